// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences a wide 74181-style operation byte-by-byte through an external 8-bit ALU.
module alu_seq_ctrl #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] op_a,
  input  logic [8*NUM_BYTES-1:0] op_b,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   cn_init,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   cout,
  output logic                   equal,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cn,
  input  logic [7:0]             alu_f,
  input  logic                   alu_cn8,
  input  logic                   alu_equal
);
  localparam int IW = $clog2(NUM_BYTES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic [8*NUM_BYTES-1:0] a_q, b_q;
  logic [3:0] s_q;
  logic m_q, carry_q, eq_q, last, accept;
  assign last = idx == IW'(NUM_BYTES - 1);
  assign accept = ena && start && state != RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (ena) state_nxt = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      m_q <= 1'b0;
      carry_q <= 1'b0;
      eq_q <= 1'b0;
      result <= '0;
    end else if (ena) begin
      if (accept) begin
        idx <= '0;
        a_q <= op_a;
        b_q <= op_b;
        s_q <= op_s;
        m_q <= op_m;
        carry_q <= cn_init;
        eq_q <= 1'b1;
        result <= '0;
      end else if (state == RUN) begin
        result[{idx, 3'b000} +: 8] <= alu_f;
        carry_q <= alu_cn8;
        eq_q <= eq_q & alu_equal;
        idx <= last ? idx : idx + 1'b1;
      end
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign cout = carry_q;
  assign equal = eq_q;
  assign alu_a = state == RUN ? a_q[{idx, 3'b000} +: 8] : '0;
  assign alu_b = state == RUN ? b_q[{idx, 3'b000} +: 8] : '0;
  assign alu_cn = state == RUN ? carry_q : 1'b1;
  assign alu_s = s_q;
  assign alu_m = m_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed checks of alu_seq_ctrl against a full-width 74181 reference model.
module tb_alu_seq_ctrl;
  localparam int NB = 4;
  localparam int W = 8 * NB;
  logic clk = 1'b0, rst_n, ena, start, op_m, cn_init;
  logic [W-1:0] op_a, op_b, result;
  logic [3:0] op_s, alu_s;
  logic busy, done, cout, equal, alu_m, alu_cn, alu_cn8, alu_equal;
  logic [7:0] alu_a, alu_b, alu_f;
  int errors = 0, checks = 0;
  alu_seq_ctrl #(.NUM_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .cn_init(cn_init),
    .busy(busy), .done(done), .result(result), .cout(cout), .equal(equal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cn8(alu_cn8), .alu_equal(alu_equal)
  );
  always #5 clk = ~clk;
  // Two cascaded 74181s, active-high data: F = X + Y + carry (arith) or ~(X ^ Y) (logic)
  logic [7:0] ax, ay;
  logic [8:0] asum;
  always_comb begin
    ax = alu_a | (alu_b & {8{alu_s[0]}}) | (~alu_b & {8{alu_s[1]}});
    ay = (alu_a & ~alu_b & {8{alu_s[2]}}) | (alu_a & alu_b & {8{alu_s[3]}});
    asum = {1'b0, ax} + {1'b0, ay} + {8'b0, ~alu_cn};
    alu_f = alu_m ? ~(ax ^ ay) : asum[7:0];
    alu_cn8 = alu_m | ~asum[8];
    alu_equal = &alu_f;
  end
  function automatic void ref_op(input logic [W-1:0] a, b, input logic [3:0] s,
                                 input logic m, cn, output logic [W-1:0] f,
                                 output logic co, eq);
    logic [W-1:0] x, y;
    logic [W:0] sum;
    x = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    y = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~cn};
    f = m ? ~(x ^ y) : sum[W-1:0];
    co = m ? 1'b1 : ~sum[W];
    eq = &f;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  logic [W-1:0] m_a, m_b, m_res;
  logic [3:0] m_s;
  logic m_m, m_co, m_eq, m_busy, m_done;
  int m_rem;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_s = '0; m_m = 1'b0; m_res = '0; m_co = 1'b0; m_eq = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    end else if (ena) begin
      if (start && (!m_busy || m_done)) begin
        m_a = op_a; m_b = op_b; m_s = op_s; m_m = op_m;
        ref_op(op_a, op_b, op_s, op_m, cn_init, m_res, m_co, m_eq);
        m_rem = NB; m_busy = 1'b1; m_done = 1'b0;
      end else if (m_rem != 0) begin
        m_rem--;
        m_done = m_rem == 0;
      end else if (m_done) begin
        m_done = 1'b0; m_busy = 1'b0;
      end
    end
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("alu_s", alu_s, m_s);
    chk("alu_m", alu_m, m_m);
    if (!m_busy || m_done) begin
      chk("result", result, m_res);
      chk("cout", cout, m_co);
      chk("equal", equal, m_eq);
      chk("alu_a_idle", alu_a, 0);
      chk("alu_b_idle", alu_b, 0);
      chk("alu_cn_idle", alu_cn, 1);
    end else begin
      chk("alu_a_run", alu_a, m_a[8*(NB-m_rem) +: 8]);
      chk("alu_b_run", alu_b, m_b[8*(NB-m_rem) +: 8]);
    end
  end
  task automatic run_op(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cn,
                        input bit hold, input int stall_at, output int cyc);
    op_a = a; op_b = b; op_s = s; op_m = m; cn_init = cn; start = 1'b1; cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      if (stall_at != 0 && cyc == stall_at) ena = 1'b0;
      if (stall_at != 0 && cyc == stall_at + 3) ena = 1'b1;
      if (done) break;
      chk("busy_wait", busy, 1);
    end
    start = 1'b0;
    chk("done_seen", done, 1);
  endtask
  int cyc;
  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0;
    op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; cn_init = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_cn", alu_cn, 1);
    run_op(32'h000000FF, 32'h00000001, 4'b1001, 1'b0, 1'b1, 0, 0, cyc);
    chk("add_lat", cyc, 5);
    chk("add_res", result, 32'h00000100);
    chk("add_cout", cout, 1);
    run_op(32'hFFFFFFFF, 32'h00000001, 4'b1001, 1'b0, 1'b1, 0, 0, cyc);
    chk("wrap_res", result, 32'h00000000);
    chk("wrap_cout", cout, 0);
    run_op(32'h12345678, 32'hFFFF0000, 4'b0110, 1'b1, 1'b1, 0, 0, cyc);
    chk("xor_res", result, 32'hEDCB5678);
    run_op(32'hCAFEBABE, 32'hCAFEBABE, 4'b0110, 1'b0, 1'b1, 0, 0, cyc);
    chk("cmp_res", result, 32'hFFFFFFFF);
    chk("cmp_eq", equal, 1);
    run_op(32'hCAFEBABE, 32'hCAFEBABF, 4'b0110, 1'b0, 1'b1, 0, 0, cyc);
    chk("b2b_lat", cyc, 5);
    chk("cmp_ne", equal, 0);
    @(negedge clk);
    run_op(32'h000000FF, 32'h00000001, 4'b1001, 1'b0, 1'b1, 1, 0, cyc);
    chk("hold_lat", cyc, 5);
    @(negedge clk);
    chk("hold_single", busy, 0);
    run_op(32'h12345678, 32'hFFFF0000, 4'b0110, 1'b1, 1'b1, 0, 2, cyc);
    chk("stall_lat", cyc, 8);
    chk("stall_res", result, 32'hEDCB5678);
    @(negedge clk);
    op_a = 32'hFFFFFFFF; op_b = 32'h00000001; op_s = 4'b1001; op_m = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_result", result, 0);
    chk("mr_cout", cout, 0);
    chk("mr_equal", equal, 0);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_alu_cn", alu_cn, 1);
    chk("mr_alu_s", alu_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h000000FF, 32'h00000001, 4'b1001, 1'b0, 1'b1, 0, 0, cyc);
    chk("post_rst_lat", cyc, 5);
    chk("post_rst_res", result, 32'h00000100);
    chk("post_rst_cout", cout, 1);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
